pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and control-flow controller for the 28-bit mini-processor. It drives the address input of the combinational instruction ROM and decodes the opcode of the returned instruction to select the next address. It handles the flow-control instructions `JMP`, `BLE`, `CALL` and `RET` through a hardware return-address stack, and it implements `NOP` with a non-zero immediate as a timed wait. It sits between the instruction ROM and the execute datapath, and it honours the datapath's stall request for multi-cycle operations such as `MUL`.

## Interface
- ADDR_W, 16, width of the program counter and ROM address.
- DEPTH, 8, number of return-address stack entries (power of two, ≥2).
- Clock  in  1  rising-edge system clock.
- Reset  in  1  asynchronous, active-high reset.
- iInstruction  in  28  instruction at oAddress from the ROM, same cycle. Fields: opcode [27:24], target/dst [23:16], imm [23:0].
- iBranchTaken  in  1  datapath comparison result for the `BLE` currently presented.
- iStall  in  1  datapath busy; hold the current address.
- oAddress  out  ADDR_W  registered program counter, ROM address.
- oValid  out  1  instruction at oAddress may be executed this cycle.
- oDepth  out  $clog2(DEPTH)+1  current stack occupancy.
- oStackOverflow  out  1  sticky flag: `CALL` issued with a full stack.
- oStackUnderflow  out  1  sticky flag: `RET` issued with an empty stack.

## Operation
- Opcodes are compared against the shared opcode macros in the definitions include. Targets are iInstruction[23:16], zero-extended to ADDR_W.
- FSM states:
  - IDLE: entered on reset; moves to RUN on the first clock edge after Reset deasserts. PC does not change.
  - RUN: oValid=1; decodes the instruction (rules below).
  - WAIT: oValid=0; counts down the NOP delay.
  - FAULT: oValid=0; PC and stack frozen; left only by Reset.
- RUN with iStall=1: PC, stack and state all hold. No decode side-effects occur, including fault detection.
- RUN with iStall=0, next PC:
  - `JMP`: target.
  - `BLE`: target if iBranchTaken=1, else PC+1.
  - `CALL`: push PC+1, jump to target. If oDepth==DEPTH: set oStackOverflow, go to FAULT, PC unchanged, no push.
  - `RET`: pop, and PC takes the popped value. If oDepth==0: set oStackUnderflow, go to FAULT, PC unchanged.
  - `NOP` with imm==0: PC+1.
  - `NOP` with imm=N>0: load a 24-bit counter with N and go to WAIT, PC held.
  - Any other opcode: PC+1.
- WAIT: the counter decrements each cycle and iStall is ignored. When the counter reaches 1, the next edge sets PC+1 and returns to RUN. A delay NOP therefore occupies N+1 cycles in total.
- PC+1 wraps from 2^ADDR_W−1 to 0 with no flag.
- Stack is LIFO, ADDR_W wide per entry. The push and its PC update occur on the same edge, as do the pop and its PC update.

## Timing
- Reset values:
  - oAddress=0, oValid=0, oDepth=0, both flags 0, state IDLE, counter 0.
  - Stack contents are don't-care.
- Reset asserted mid-operation, including in WAIT or FAULT, applies the reset values immediately (asynchronous).
- oValid is a decode of the state register: 1 only in RUN, and it stays 1 while iStall is high.
- Every flow change takes effect at the next rising edge. The sequencer has one-cycle fetch-to-next-fetch latency and no delay slots.
- The datapath must drive iBranchTaken and iStall combinationally within the cycle that the instruction is presented.
- Flags and FAULT are registered. They become visible the cycle after the offending instruction.

## Test plan
- Reset release: Reset high for 3 cycles, then low. Required: oAddress=0 and oValid=0 for one cycle (IDLE), then oValid=1 with oAddress=0. Reasserting Reset during later execution returns the outputs to 0 asynchronously.
- Delay NOP: address 0 holds `NOP`,24'd3. Required: oAddress=0 for 4 cycles, with oValid pattern 1,0,0,0, then oAddress=1 with oValid=1.
- Call/return: `CALL` 8'd18 at address 11. Required: next oAddress=18 and oDepth=1. A `RET` at 22 then gives oAddress=12 and oDepth=0.
- Branch: `BLE` target 10 at address 13. iBranchTaken=1 → oAddress=10. iBranchTaken=0 → oAddress=14.
- Stall: `JMP` 8'd4 at address 17 with iStall high for 3 cycles. Required: oAddress=17 for those 3 cycles, oValid=1, then oAddress=4. A full-stack `CALL` held under iStall raises no flag until iStall drops.
- Stack faults (DEPTH=8):
  - 9 nested CALLs: after the 9th, oStackOverflow=1, oValid=0, oDepth=8, and oAddress frozen at the 9th CALL's address.
  - After reset, a `RET` with an empty stack gives oStackUnderflow=1 and FAULT.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and flow control for the 28-bit mini-processor: addresses the
// instruction ROM and handles JMP/BLE/CALL/RET, timed NOP waits and datapath stalls.

`ifndef OP_NOP
`define OP_NOP  4'h0
`endif
`ifndef OP_JMP
`define OP_JMP  4'h9
`endif
`ifndef OP_BLE
`define OP_BLE  4'hA
`endif
`ifndef OP_CALL
`define OP_CALL 4'hB
`endif
`ifndef OP_RET
`define OP_RET  4'hC
`endif

module pc_sequencer #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [27:0]              iInstruction,
   input  logic                     iBranchTaken,
   input  logic                     iStall,
   output logic [ADDR_W-1:0]        oAddress,
   output logic                     oValid,
   output logic [$clog2(DEPTH):0]   oDepth,
   output logic                     oStackOverflow,
   output logic                     oStackUnderflow
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam logic [IW:0]       DEPTH_FULL = (IW+1)'(DEPTH);
   localparam logic [IW:0]       DEPTH_ONE  = (IW+1)'(1);
   localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

   typedef enum logic [1:0] {StIdle, StRun, StWait, StFault} state_t;

   state_t            state;
   logic [23:0]       cnt;
   logic [ADDR_W-1:0] stack_mem [DEPTH];
   logic [3:0]        opcode;
   logic [23:0]       imm;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] stack_top;
   logic [IW-1:0]     top_idx;
   logic              decode;
   logic              full;
   logic              empty;
   logic              push;

   assign opcode    = iInstruction[27:24];
   assign imm       = iInstruction[23:0];
   assign target    = ADDR_W'(iInstruction[23:16]);
   assign pc_inc    = oAddress + PC_ONE;
   assign top_idx   = oDepth[IW-1:0] - IW'(1);
   assign stack_top = stack_mem[top_idx];
   assign full      = (oDepth == DEPTH_FULL);
   assign empty     = (oDepth == '0);
   assign decode    = (state == StRun) && !iStall;
   assign push      = decode && (opcode == `OP_CALL) && !full;
   assign oValid    = (state == StRun);

   // Stack contents need no reset; occupancy lives in oDepth.
   always_ff @(posedge Clock) begin
      if (push) begin
         stack_mem[oDepth[IW-1:0]] <= pc_inc;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state           <= StIdle;
         oAddress        <= '0;
         oDepth          <= '0;
         oStackOverflow  <= 1'b0;
         oStackUnderflow <= 1'b0;
         cnt             <= '0;
      end else begin
         unique case (state)
            StIdle: state <= StRun;
            StRun: begin
               if (decode) begin
                  case (opcode)
                     `OP_JMP: oAddress <= target;
                     `OP_BLE: oAddress <= iBranchTaken ? target : pc_inc;
                     `OP_CALL: begin
                        if (full) begin
                           oStackOverflow <= 1'b1;
                           state          <= StFault;
                        end else begin
                           oAddress <= target;
                           oDepth   <= oDepth + DEPTH_ONE;
                        end
                     end
                     `OP_RET: begin
                        if (empty) begin
                           oStackUnderflow <= 1'b1;
                           state           <= StFault;
                        end else begin
                           oAddress <= stack_top;
                           oDepth   <= oDepth - DEPTH_ONE;
                        end
                     end
                     `OP_NOP: begin
                        if (imm != 24'd0) begin
                           cnt   <= imm;
                           state <= StWait;
                        end else begin
                           oAddress <= pc_inc;
                        end
                     end
                     default: oAddress <= pc_inc;
                  endcase
               end
            end
            // Stall is ignored here; the NOP owns the pipeline until it expires.
            StWait: begin
               cnt <= cnt - 24'd1;
               if (cnt == 24'd1) begin
                  oAddress <= pc_inc;
                  state    <= StRun;
               end
            end
            StFault: state <= StFault;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based behavioural model checked every
// cycle, plus literal expectations at the interesting points of each program.

module tb_pc_sequencer;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DEPTH  = 8;
   localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, MUL = 4'h3, JMP = 4'h9, BLE = 4'hA,
                          CALL = 4'hB, RET = 4'hC;

   logic                   Clock;
   logic                   Reset;
   logic [27:0]            iInstruction;
   logic                   iBranchTaken;
   logic                   iStall;
   logic [ADDR_W-1:0]      oAddress;
   logic                   oValid;
   logic [$clog2(DEPTH):0] oDepth;
   logic                   oStackOverflow;
   logic                   oStackUnderflow;

   logic [27:0] rom [256];
   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // Behavioural model state
   logic [15:0] m_pc;
   logic [15:0] stk[$];
   int          m_wait;
   bit          m_idle, m_fault, m_ovf, m_unf;

   pc_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .iInstruction(iInstruction),
      .iBranchTaken(iBranchTaken),
      .iStall(iStall),
      .oAddress(oAddress),
      .oValid(oValid),
      .oDepth(oDepth),
      .oStackOverflow(oStackOverflow),
      .oStackUnderflow(oStackUnderflow)
   );

   assign iInstruction = rom[oAddress[7:0]];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] op_t(input logic [3:0] op, input logic [7:0] t);
      return {op, t, 16'h0000};
   endfunction

   function automatic logic [27:0] op_i(input logic [3:0] op, input logic [23:0] imm);
      return {op, imm};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = {ADD, 24'h0};
   endtask

   task automatic model_reset();
      m_pc = '0;
      stk.delete();
      m_wait = 0;
      m_idle = 1;
      m_fault = 0;
      m_ovf = 0;
      m_unf = 0;
   endtask

   task automatic model_step(input logic st, input logic br);
      logic [27:0] ins;
      logic [15:0] tgt;
      ins = rom[m_pc[7:0]];
      tgt = {8'h00, ins[23:16]};
      if (m_fault) begin
         // frozen until reset
      end else if (m_idle) begin
         m_idle = 0;
      end else if (m_wait > 0) begin
         if (m_wait == 1) m_pc = m_pc + 16'd1;
         m_wait--;
      end else if (!st) begin
         case (ins[27:24])
            JMP: m_pc = tgt;
            BLE: m_pc = br ? tgt : m_pc + 16'd1;
            CALL: begin
               if (stk.size() == DEPTH) begin
                  m_ovf = 1;
                  m_fault = 1;
               end else begin
                  stk.push_back(m_pc + 16'd1);
                  m_pc = tgt;
               end
            end
            RET: begin
               if (stk.size() == 0) begin
                  m_unf = 1;
                  m_fault = 1;
               end else begin
                  m_pc = stk.pop_back();
               end
            end
            NOP: begin
               if (ins[23:0] != 24'd0) m_wait = int'(ins[23:0]);
               else m_pc = m_pc + 16'd1;
            end
            default: m_pc = m_pc + 16'd1;
         endcase
      end
   endtask

   always @(negedge Clock) begin
      if (chk_en) begin
         chk("addr", 32'(oAddress), 32'(m_pc));
         chk("valid", 32'(oValid), 32'(!m_idle && !m_fault && m_wait == 0));
         chk("depth", 32'(oDepth), stk.size());
         chk("ovf", 32'(oStackOverflow), 32'(m_ovf));
         chk("unf", 32'(oStackUnderflow), 32'(m_unf));
      end
   end

   task automatic cycle(input logic st, input logic br);
      iStall = st;
      iBranchTaken = br;
      @(posedge Clock);
      model_step(st, br);
      @(negedge Clock);
   endtask

   task automatic do_reset();
      chk_en = 0;
      iStall = 0;
      iBranchTaken = 0;
      Reset = 1;
      repeat (3) @(negedge Clock);
      chk("rst_addr", 32'(oAddress), 0);
      chk("rst_valid", 32'(oValid), 0);
      Reset = 0;
      model_reset();
      #1;
      chk("idle_addr", 32'(oAddress), 0);
      chk("idle_valid", 32'(oValid), 0);
      chk_en = 1;
   endtask

   task automatic async_reset_check();
      chk_en = 0;
      #2 Reset = 1;
      #1;
      chk("areset_addr", 32'(oAddress), 0);
      chk("areset_valid", 32'(oValid), 0);
      chk("areset_depth", 32'(oDepth), 0);
      chk("areset_ovf", 32'(oStackOverflow), 0);
      chk("areset_unf", 32'(oStackUnderflow), 0);
   endtask

   initial begin
      iStall = 0;
      iBranchTaken = 0;
      Reset = 1;

      // Program 1: delay NOP, nested call/return, branch, stall, wait under stall
      clear_rom();
      rom[0]  = op_i(NOP, 24'd3);
      rom[1]  = op_t(JMP, 8'd11);
      rom[11] = op_t(CALL, 8'd18);
      rom[19] = op_t(CALL, 8'd25);
      rom[25] = op_i(RET, 24'd0);
      rom[22] = op_i(RET, 24'd0);
      rom[13] = op_t(BLE, 8'd10);
      rom[10] = op_t(JMP, 8'd13);
      rom[14] = op_t(JMP, 8'd17);
      rom[17] = op_t(JMP, 8'd4);
      rom[5]  = op_i(NOP, 24'd0);
      rom[6]  = op_i(MUL, 24'h000012);
      rom[7]  = op_i(NOP, 24'd2);
      do_reset();
      cycle(0, 0);
      chk("run_valid", 32'(oValid), 1);
      chk("run_addr", 32'(oAddress), 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0);
         chk("wait_valid", 32'(oValid), 0);
         chk("wait_addr", 32'(oAddress), 0);
      end
      cycle(0, 0);
      chk("nop_done_addr", 32'(oAddress), 1);
      chk("nop_done_valid", 32'(oValid), 1);
      cycle(0, 0);
      cycle(0, 0);
      chk("call_addr", 32'(oAddress), 18);
      chk("call_depth", 32'(oDepth), 1);
      chk("model_call", 32'(m_pc), 18);
      cycle(0, 0);
      cycle(0, 0);
      chk("nest_addr", 32'(oAddress), 25);
      chk("nest_depth", 32'(oDepth), 2);
      cycle(0, 0);
      chk("lifo_addr", 32'(oAddress), 20);
      chk("lifo_depth", 32'(oDepth), 1);
      cycle(0, 0);
      cycle(0, 0);
      cycle(0, 0);
      chk("ret_addr", 32'(oAddress), 12);
      chk("ret_depth", 32'(oDepth), 0);
      cycle(0, 0);
      cycle(0, 1);
      chk("ble_taken", 32'(oAddress), 10);
      cycle(0, 0);
      cycle(0, 0);
      chk("ble_not_taken", 32'(oAddress), 14);
      cycle(0, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0);
         chk("stall_addr", 32'(oAddress), 17);
         chk("stall_valid", 32'(oValid), 1);
      end
      cycle(0, 0);
      chk("jmp_addr", 32'(oAddress), 4);
      chk("model_jmp", 32'(m_pc), 4);
      cycle(0, 0);
      cycle(0, 0);
      chk("nop0_addr", 32'(oAddress), 6);
      cycle(0, 0);
      cycle(0, 0);
      chk("nop2_valid", 32'(oValid), 0);
      cycle(1, 0);
      cycle(1, 0);
      chk("wait_stall_addr", 32'(oAddress), 8);
      chk("wait_stall_valid", 32'(oValid), 1);
      async_reset_check();

      // Program 2: nine nested calls overflow an eight-deep stack
      clear_rom();
      for (int i = 0; i < 9; i++) rom[i] = op_t(CALL, 8'(i + 1));
      do_reset();
      cycle(0, 0);
      repeat (8) cycle(0, 0);
      chk("full_depth", 32'(oDepth), 8);
      chk("full_addr", 32'(oAddress), 8);
      repeat (2) begin
         cycle(1, 0);
         chk("stall_full_ovf", 32'(oStackOverflow), 0);
         chk("stall_full_valid", 32'(oValid), 1);
      end
      cycle(0, 0);
      chk("ovf_flag", 32'(oStackOverflow), 1);
      chk("ovf_valid", 32'(oValid), 0);
      chk("ovf_depth", 32'(oDepth), 8);
      chk("ovf_addr", 32'(oAddress), 8);
      repeat (3) begin
         cycle(0, 1);
         chk("fault_frozen", 32'(oAddress), 8);
      end
      async_reset_check();

      // Program 3: return with an empty stack
      clear_rom();
      rom[0] = op_i(RET, 24'd0);
      do_reset();
      cycle(0, 0);
      cycle(0, 0);
      chk("unf_flag", 32'(oStackUnderflow), 1);
      chk("unf_valid", 32'(oValid), 0);
      chk("unf_addr", 32'(oAddress), 0);
      repeat (2) cycle(0, 0);
      chk("unf_sticky", 32'(oStackUnderflow), 1);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
